pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Sequences the board PLL (50 MHz in, 112.5 MHz system clock out): pulses the PLL RST,
//  waits for a filtered LOCKED, then releases the downstream reset domains one stage at a time.
//  Runs on the free-running 50 MHz board clock, never on the PLL output.
//  Monitors lock in RUN, and on lock loss or a relock request restarts the whole sequence.
// PARAMETERS
//  RST_CYCLES     16     cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT   65536  cycles to wait for lock before an attempt counts as failed
//  SETTLE_CYCLES  1024   consecutive synced-lock cycles required before release
//  NUM_STAGES     3      number of sequenced active-low reset outputs (1..8)
//  STAGE_GAP      16     cycles between successive stage releases (>=1)
//  MAX_RETRIES    3      failed attempts tolerated before fail is raised (used with retry macro)
// PORTS
//  clk          in   1           free-running 50 MHz board clock
//  rst_n        in   1           asynchronous, active-low reset
//  pll_locked   in   1           PLL LOCKED output, asynchronous to clk
//  relock_req   in   1           1-cycle pulse: force full re-sequence (e.g. clock reprogram)
//  pll_rst      out  1           PLL RST, active-high
//  rst_out_n    out  NUM_STAGES  staged resets, active-low; bit 0 released first
//  ready        out  1           1 only in RUN state
//  fail         out  1           sticky, PLL never locked within retry budget
//  retry_cnt    out  4           failed attempts since last rst_n, saturating at 15
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low (rst_n). While rst_n=0: pll_rst=1, rst_out_n=0,
//   ready=0, fail=0, retry_cnt=0, state=S_PLL_RST, all counters 0.
//  pll_locked passes through a 2-flop synchroniser (lk_s); all decisions use lk_s (2-cycle latency).
//  S_PLL_RST: pll_rst=1 for exactly RST_CYCLES cycles, then go to S_WAIT_LOCK and set pll_rst=0.
//  S_WAIT_LOCK: timer counts each cycle. lk_s=1 -> S_SETTLE with settle counter 0.
//   Timer reaches LOCK_TIMEOUT-1 with lk_s=0 -> timeout (see CONFIGURATION).
//  S_SETTLE: counter increments while lk_s=1. Any lk_s=0 cycle -> S_WAIT_LOCK, timer restarts at 0.
//   Counter reaches SETTLE_CYCLES-1 -> S_RELEASE, stage index 0.
//  S_RELEASE: release rst_out_n[0] on entry. Release next bit every STAGE_GAP cycles.
//   A released bit stays 1 (monotone). One cycle after the last bit is released -> S_RUN.
//   lk_s=0 here -> immediately rst_out_n=0 and go to S_PLL_RST.
//  S_RUN: ready=1. lk_s=0 for one cycle -> ready=0 and rst_out_n=0 in the same registered
//   update, then S_PLL_RST. Lock loss in RUN does not increment retry_cnt.
//  relock_req in any state except S_FAIL: same as lock loss; it has priority over every
//   transition in that cycle. A relock_req arriving while in S_PLL_RST restarts the RST_CYCLES count.
//  S_FAIL: pll_rst=1 and rst_out_n=0, fail=1. Leave S_FAIL only by rst_n.
//  All outputs are registered, glitch-free, and change only on the clk rising edge or on rst_n.
//  Counters are sized $clog2 of their maximum and cannot wrap. retry_cnt saturates at 15.
// CONFIGURATION
//  PLL_RETRY_EN defined: timeout increments retry_cnt. If retry_cnt (post-increment) > MAX_RETRIES,
//   go to S_FAIL, else go to S_PLL_RST for a new attempt.
//  PLL_RETRY_EN undefined: no timeout. S_WAIT_LOCK waits forever, fail is tied 0,
//   retry_cnt is tied 0, and S_FAIL is unreachable.
// STRUCTURE
//  Package pll_seq_pkg: state enum (S_PLL_RST, S_WAIT_LOCK, S_SETTLE, S_RELEASE, S_RUN, S_FAIL),
//   RETRY_W=4 and the counter-width helper functions.
//  Sub-module sync_2ff: generic 2-flop synchroniser with async active-low reset to 0,
//   used for pll_locked.
//  Top contains the FSM, a shared down-counter reused for each timed state, and the stage register.
// TESTING
//  Use RST_CYCLES=4, LOCK_TIMEOUT=64, SETTLE_CYCLES=8, NUM_STAGES=3, STAGE_GAP=4, MAX_RETRIES=2.
//  1 Power-up: rst_n released, pll_locked rises 10 cycles later -> pll_rst high exactly 4 cycles.
//    rst_out_n goes 001, 011, 111, 4 cycles apart. ready=1 one cycle after 111.
//  2 Lock glitch during settle: pll_locked low 1 cycle at settle count 5 -> settle restarts.
//    rst_out_n[0] release is delayed by >=8 cycles after the glitch.
//  3 Lock loss in RUN: drop pll_locked -> within 3 cycles ready=0, rst_out_n=000, pll_rst=1
//    for 4 cycles. retry_cnt is unchanged.
//  4 relock_req pulse in RUN with pll_locked steady 1 -> full re-sequence, identical timing to case 1.
//  5 PLL_RETRY_EN, pll_locked held 0 -> 3 timeouts, retry_cnt=3, fail=1, pll_rst stuck 1.
//    relock_req is then ignored. rst_n pulse clears fail.
//  6 No macro, pll_locked held 0 for 1000 cycles -> stays in S_WAIT_LOCK, fail=0, pll_rst=0.
//    Raising pll_locked then completes the sequence normally.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared state encoding and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_SETTLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } pll_state_e;

    localparam int RETRY_W   = 4;
    localparam int RETRY_MAX = 15;

    // Bits needed for a counter running 0..max_val-1 (never narrower than 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, asynchronous active-low reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-filter / staged reset release sequencer on the board clock.
// Define PLL_RETRY_EN to enable lock timeouts, retry counting and the sticky fail state.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 1024,
    parameter int NUM_STAGES    = 3,
    parameter int STAGE_GAP     = 16,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  ready,
    output logic                  fail,
    output logic [RETRY_W-1:0]    retry_cnt
);

    localparam int CW = cnt_w(max4(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES, STAGE_GAP));
    localparam int IW = cnt_w(NUM_STAGES);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);

    pll_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] stg_d;
    logic                  lk_s;
    logic                  restart;

`ifdef PLL_RETRY_EN
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic                  fail_q;
`endif

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // One counter is shared by every timed state; each state clears it on exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stg_d   = rst_out_n;
        restart = 1'b0;
`ifdef PLL_RETRY_EN
        retry_d = retry_q;
`endif
        if (relock_req && state_q != S_FAIL) begin
            restart = 1'b1;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk_s) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q != TMO_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef PLL_RETRY_EN
                    else begin
                        retry_d = (retry_q == RETRY_W'(RETRY_MAX)) ? retry_q : retry_q + 1'b1;
                        if (int'(retry_d) > MAX_RETRIES) state_d = S_FAIL;
                        else                             restart = 1'b1;
                    end
`endif
                end
                S_SETTLE: begin
                    if (!lk_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == SET_LAST) begin
                        state_d  = S_RELEASE;
                        cnt_d    = '0;
                        idx_d    = '0;
                        stg_d[0] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!lk_s) begin
                        restart = 1'b1;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                    end else if (cnt_q == GAP_LAST) begin
                        idx_d        = idx_q + 1'b1;
                        stg_d[idx_d] = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lk_s) restart = 1'b1;
                end
                S_FAIL: begin
                end
                default: restart = 1'b1;
            endcase
        end
        if (restart) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            idx_d   = '0;
            stg_d   = '0;
        end
    end

    // Outputs are registered from the next state so they settle on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_n <= '0;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_n <= stg_d;
            pll_rst   <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
            ready     <= (state_d == S_RUN);
        end
    end

`ifdef PLL_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= '0;
            fail_q  <= 1'b0;
        end else begin
            retry_q <= retry_d;
            fail_q  <= (state_d == S_FAIL);
        end
    end

    assign retry_cnt = retry_q;
    assign fail      = fail_q;
`else
    assign retry_cnt = '0;
    assign fail      = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed tables, corner sequences and a randomized lock trace
// compared each cycle against a time-based reference model.
module tb_pll_reset_sequencer;

    localparam int RST     = 4;
    localparam int TMO     = 64;
    localparam int SET     = 8;
    localparam int NS      = 3;
    localparam int GAP     = 4;
    localparam int MAXR    = 2;
    localparam int REL_END = (NS - 1) * GAP + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          relock_req = 1'b0;
    logic          pll_rst, ready, fail;
    logic [NS-1:0] rst_out_n;
    logic [3:0]    retry_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (TMO),
        .SETTLE_CYCLES (SET),
        .NUM_STAGES    (NS),
        .STAGE_GAP     (GAP),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .rst_out_n  (rst_out_n),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    // Reference model in elapsed-time terms: edges since restart, zero-run while waiting,
    // consecutive synced-lock edges, and edges since the first stage was released.
    int m_since, m_idle, m_run, m_rel, m_retry;
    bit m_fail, h1, h2;

    task automatic m_restart();
        m_since = 0; m_idle = 0; m_run = 0; m_rel = -1;
    endtask

    task automatic m_clear();
        m_restart();
        m_retry = 0; m_fail = 0; h1 = 0; h2 = 0;
    endtask

    task automatic m_edge(input bit lk, input bit rq);
        bit s;
        if (!rst_n) begin
            m_clear();
            return;
        end
        s = h2; h2 = h1; h1 = lk;
        if (m_fail) begin
        end else if (rq) begin
            m_restart();
        end else if (m_since < RST) begin
            m_since++;
        end else if (m_rel >= 0) begin
            if (!s) m_restart();
            else if (m_rel < REL_END) m_rel++;
        end else if (s) begin
            if (m_run == SET) m_rel = 0;
            else m_run++;
        end else begin
            if (m_run > 0) begin
                m_run = 0; m_idle = 0;
            end else if (m_idle < TMO) begin
                m_idle++;
            end
`ifdef PLL_RETRY_EN
            if (m_idle == TMO) begin
                if (m_retry < 15) m_retry++;
                if (m_retry > MAXR) m_fail = 1;
                else m_restart();
            end
`endif
        end
    endtask

    function automatic logic [9:0] m_expect();
        logic [NS-1:0] r;
        for (int k = 0; k < NS; k++) r[k] = (m_rel >= k * GAP);
        return {(m_fail || m_since < RST), r, (m_rel == REL_END), m_fail, 4'(m_retry)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit lk, input bit rq);
        @(negedge clk);
        pll_locked = lk;
        relock_req = rq;
        @(posedge clk);
        m_edge(lk, rq);
        #1;
        chk("model", {pll_rst, rst_out_n, ready, fail, retry_cnt}, m_expect());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
        m_clear();
        #1;
        chk("reset_state", {pll_rst, rst_out_n, ready, fail, retry_cnt}, {1'b1, 3'b000, 1'b0, 1'b0, 4'd0});
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int            grp;
        int            edge_n;
        bit            lk;
        bit            pll_rst;
        logic [NS-1:0] rst_out_n;
        bit            ready;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    // Applies the entries of one group; edge_n counts edges from the start of the group,
    // lk is driven on every edge up to and including that entry's edge.
    task automatic run_table(input int g);
        int e;
        e = 0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].grp == g) begin
                while (e < vecs[i].edge_n) begin
                    step(vecs[i].lk, 0);
                    e++;
                end
                chk($sformatf("tbl%0d_e%0d", g, e), {pll_rst, rst_out_n, ready},
                    {vecs[i].pll_rst, vecs[i].rst_out_n, vecs[i].ready});
            end
        end
    endtask

    initial begin
        bit lk;
        int hold;

        // group 1: power-up, lock at edge 11; group 2: relock pulse in RUN with lock steady
        vecs[0]  = '{1,  3, 0, 1, 3'b000, 0};
        vecs[1]  = '{1,  4, 0, 0, 3'b000, 0};
        vecs[2]  = '{1, 10, 0, 0, 3'b000, 0};
        vecs[3]  = '{1, 11, 1, 0, 3'b000, 0};
        vecs[4]  = '{1, 20, 1, 0, 3'b000, 0};
        vecs[5]  = '{1, 21, 1, 0, 3'b001, 0};
        vecs[6]  = '{1, 24, 1, 0, 3'b001, 0};
        vecs[7]  = '{1, 25, 1, 0, 3'b011, 0};
        vecs[8]  = '{1, 28, 1, 0, 3'b011, 0};
        vecs[9]  = '{1, 29, 1, 0, 3'b111, 0};
        vecs[10] = '{1, 30, 1, 0, 3'b111, 1};
        vecs[11] = '{2,  3, 1, 1, 3'b000, 0};
        vecs[12] = '{2,  4, 1, 0, 3'b000, 0};
        vecs[13] = '{2, 12, 1, 0, 3'b000, 0};
        vecs[14] = '{2, 13, 1, 0, 3'b001, 0};
        vecs[15] = '{2, 16, 1, 0, 3'b001, 0};
        vecs[16] = '{2, 17, 1, 0, 3'b011, 0};
        vecs[17] = '{2, 20, 1, 0, 3'b011, 0};
        vecs[18] = '{2, 21, 1, 0, 3'b111, 0};
        vecs[19] = '{2, 22, 1, 0, 3'b111, 1};

        // Power-up sequence
        do_reset();
        run_table(1);

        // Lock loss in RUN
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("loss_ready_hold", ready, 1);
        step(0, 0);
        chk("loss_drop", {pll_rst, rst_out_n, ready}, {1'b1, 3'b000, 1'b0});
        chk("loss_retry", retry_cnt, 0);
        repeat (3) step(0, 0);
        chk("loss_rst_hi", pll_rst, 1);
        step(0, 0);
        chk("loss_rst_lo", pll_rst, 0);
        repeat (40) step(1, 0);
        chk("loss_recover", {rst_out_n, ready}, {3'b111, 1'b1});

        // Relock request in RUN
        step(1, 1);
        chk("relock_edge", {pll_rst, rst_out_n, ready}, {1'b1, 3'b000, 1'b0});
        run_table(2);

        // Lock glitch at settle count 5
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            step(e != 9, 0);
            if (e == 13) chk("glitch_e13", rst_out_n, 3'b000);
            if (e == 19) chk("glitch_e19", rst_out_n, 3'b000);
            if (e == 20) chk("glitch_e20", rst_out_n, 3'b001);
        end

`ifdef PLL_RETRY_EN
        // Three timeouts lead to sticky fail
        do_reset();
        repeat (100) step(0, 0);
        chk("retry_after_1", retry_cnt, 1);
        repeat (110) step(0, 0);
        chk("fail_state", {pll_rst, rst_out_n, ready, fail, retry_cnt},
            {1'b1, 3'b000, 1'b0, 1'b1, 4'd3});
        step(0, 1);
        repeat (30) step(1, 0);
        chk("fail_sticky", {pll_rst, rst_out_n, ready, fail}, {1'b1, 3'b000, 1'b0, 1'b1});
        do_reset();
        chk("fail_cleared", {fail, retry_cnt}, {1'b0, 4'd0});
`else
        // No timeout: wait for lock indefinitely
        do_reset();
        repeat (1000) step(0, 0);
        chk("wait_forever", {pll_rst, rst_out_n, ready, fail, retry_cnt},
            {1'b0, 3'b000, 1'b0, 1'b0, 4'd0});
        repeat (40) step(1, 0);
        chk("late_lock", {rst_out_n, ready}, {3'b111, 1'b1});
`endif

        // Randomized lock trace with occasional relock requests
        do_reset();
        lk = 1'b0;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            if (hold == 0) begin
                lk = ~lk;
                if (lk) hold = $urandom_range(5, 120);
                else if ($urandom_range(0, 9) == 0) hold = $urandom_range(60, 90);
                else hold = $urandom_range(1, 4);
            end else begin
                hold--;
            end
            step(lk, $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
